hs32_fetch: RTL and testbench
=============================

HS32_FETCH -- requirements
Module: hs32_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 4, prefetch buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 halt_i  input  1  when high, no new memory requests issue.
REQ-006 flush_i  input  1  redirect strobe, one cycle.
REQ-007 flush_pc_i  input  32  redirect target, sampled when flush_i is high.
REQ-008 mem_req_o  output  1  fetch request valid.
REQ-009 mem_addr_o  output  32  fetch word address.
REQ-010 mem_gnt_i  input  1  request accepted this cycle when mem_req_o is also high.
REQ-011 mem_rvalid_i  input  1  read data valid; responses return in request order, at least one cycle after grant.
REQ-012 mem_rdata_i  input  32  read data.
REQ-013 valid_o  output  1  instruction available to the pipeline.
REQ-014 ready_i  input  1  pipeline accepts; connects to pipeline ready_o.
REQ-015 op_o  output  32  instruction word; connects to pipeline op_i.
REQ-016 pc_o  output  32  address of op_o.

Function
REQ-017 The block SHALL implement FSM states IDLE, FETCH, HALTED; reset enters IDLE; IDLE -> FETCH after exactly one cycle.
REQ-018 FETCH -> HALTED when halt_i is high; HALTED -> FETCH when halt_i is low; outstanding responses and buffered entries still drain and present in HALTED.
REQ-019 mem_req_o SHALL be high only in FETCH with credits available: outstanding + occupancy < DEPTH.
REQ-020 mem_addr_o SHALL equal the fetch PC; on grant, fetch PC increments by 4 and wraps modulo 2^32.
REQ-021 mem_req_o and mem_addr_o SHALL hold stable until granted, unless flush_i is asserted.
REQ-022 Each non-discarded response SHALL be written into the buffer together with its request address; valid_o rises the cycle after mem_rvalid_i (one-cycle latency).
REQ-023 A buffer entry SHALL leave on valid_o && ready_i; op_o and pc_o SHALL hold stable while valid_o && !ready_i.
REQ-024 Simultaneous write and read SHALL be legal at any occupancy, including full, and leave occupancy unchanged.
REQ-025 flush_i SHALL empty the buffer, drop valid_o next cycle, and set fetch PC to flush_pc_i; the first post-flush request issues the following cycle.
REQ-026 On flush, all outstanding requests, including one granted in the flush cycle, SHALL be counted as discard; their responses, including one in the flush cycle, are dropped.
REQ-027 A flush while discards are pending SHALL add to the discard count; new requests may issue while discards are pending.
REQ-028 The outstanding and discard counters SHALL be $clog2(DEPTH)+1 bits wide and never overflow, because credits bound them to DEPTH.
REQ-029 mem_rvalid_i with zero outstanding SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately force mem_req_o=0 and valid_o=0, mem_addr_o=RESET_PC, op_o=0, pc_o=0, all counters zero, and state IDLE.
REQ-031 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses arriving after release with zero outstanding are ignored per REQ-029.

Structure
REQ-032 The FSM state enum and the instruction width constant (32) SHALL live in the shared hs32 package.
REQ-033 The buffer SHALL be a sub-module, hs32_fetch_fifo (DEPTH x 64-bit, {pc, op}), with push, pop, full, empty and count.

Verification
REQ-034 Reset release, mem_gnt_i=1, one-cycle memory -> requests to 0,4,8,12; op_o/pc_o sequence matches memory, one instruction per cycle with ready_i=1.
REQ-035 ready_i=0 for 10 cycles -> exactly DEPTH=4 entries plus 0 outstanding, mem_req_o low; op_o stable; release -> in-order drain with no loss.
REQ-036 Three outstanding at 0x10..0x18, flush_i to 0x100 -> the three responses are dropped; the next valid_o shows pc_o=0x100.
REQ-037 flush_i in the same cycle as a grant and an rvalid -> both are discarded; the discard count equals outstanding+1 minus 1 returned.
REQ-038 halt_i high mid-stream -> no grants after the current one; the buffer drains; halt_i low -> fetch resumes at the next sequential PC.
REQ-039 fetch PC 0xFFFFFFFC -> the next request is 0x00000000; reset asserted with 2 outstanding -> outputs are zero asynchronously, and the post-release fetch is at RESET_PC.

Source files
------------

// File: rtl/hs32_pkg.sv
// Shared HS32 definitions: instruction width and fetch-unit FSM states.
package hs32_pkg;

    localparam int unsigned INSN_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/hs32_fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, op}, first-word-fall-through head,
// push and pop legal together at any occupancy including full.
module hs32_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch unit: credit-limited in-order memory requests,
// flush with discard accounting for in-flight responses, prefetch buffer.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_pc_i,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INSN_W-1:0] mem_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [INSN_W-1:0] op_o,
    output logic [31:0]       pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [31:0]           fetch_pc;
    logic [31:0]           resp_pc;
    logic [CW-1:0]         live_cnt;
    logic [CW-1:0]         disc_cnt;
    logic [CW-1:0]         count;
    logic [CW+1:0]         used;
    logic                  gnt;
    logic                  rsp;
    logic                  rsp_live;
    logic                  rsp_disc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [2*INSN_W-1:0]   head;

    // Discarded requests still occupy the memory pipe, so they consume credits.
    assign used     = (CW+2)'(live_cnt) + (CW+2)'(disc_cnt) + (CW+2)'(count);
    assign gnt      = mem_req_o && mem_gnt_i;
    assign rsp      = mem_rvalid_i && ((live_cnt != '0) || (disc_cnt != '0));
    assign rsp_disc = rsp && (disc_cnt != '0);
    assign rsp_live = rsp && (disc_cnt == '0);
    assign push     = rsp_live && !flush_i && (!full || pop);
    assign pop      = valid_o && ready_i;

    assign mem_addr_o = fetch_pc;
    assign valid_o    = !empty;
    assign op_o       = empty ? '0 : head[INSN_W-1:0];
    assign pc_o       = empty ? '0 : head[2*INSN_W-1:INSN_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req_o  = 1'b0;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH: begin
                mem_req_o = (used < DEPTH_W);
                if (halt_i) state_next = HALTED;
            end
            HALTED:  if (!halt_i) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Responses return in order; discards are always the oldest in flight,
    // so the live stream's addresses follow resp_pc sequentially.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            live_cnt <= '0;
            disc_cnt <= '0;
        end else if (flush_i) begin
            fetch_pc <= flush_pc_i;
            resp_pc  <= flush_pc_i;
            live_cnt <= '0;
            disc_cnt <= disc_cnt + live_cnt + CW'(gnt) - CW'(rsp);
        end else begin
            if (gnt)      fetch_pc <= fetch_pc + 32'd4;
            if (rsp_live) resp_pc  <= resp_pc + 32'd4;
            live_cnt <= live_cnt + CW'(gnt) - CW'(rsp_live);
            disc_cnt <= disc_cnt - CW'(rsp_disc);
        end
    end

    hs32_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2*INSN_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .din   ({resp_pc, mem_rdata_i}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hs32_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        halt_i       = 1'b0;
    logic        flush_i      = 1'b0;
    logic [31:0] flush_pc_i   = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i    = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i  = 32'h0;
    logic        valid_o;
    logic        ready_i      = 1'b0;
    logic [31:0] op_o;
    logic [31:0] pc_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    bit mem_hold = 1'b0;
    bit spurious = 1'b0;
    int lat_extra = 0;
    int last_due  = 0;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] gnt_log [$];
    logic [31:0] acc_pc  [$];
    logic [31:0] acc_op  [$];
    int          acc_cyc [$];

    hs32_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .halt_i       (halt_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .op_o         (op_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        check1({name, "_valid_seen"}, valid_o, 1'b1);
    endtask

    // Memory: in-order responses, at least one cycle after grant.
    always @(negedge clk) begin
        int d;
        if (reset && mem_req_o && mem_gnt_i) begin
            d = cyc + 1 + int'($urandom_range(0, lat_extra));
            if (d < last_due) d = last_due;
            last_due = d;
            mq_addr.push_back(mem_addr_o);
            mq_due.push_back(d);
            gnt_log.push_back(mem_addr_o);
        end
        if (reset && valid_o && ready_i) begin
            acc_pc.push_back(pc_o);
            acc_op.push_back(op_o);
            acc_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        mem_rvalid_i = 1'b0;
        if (spurious) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
        end else if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    end

    // Reference model: in-flight request list and buffer contents as queues.
    logic [31:0] m_pc     = RESET_PC;
    bit          m_idle   = 1'b1;
    bit          m_halted = 1'b0;
    logic [31:0] inf_addr [$];
    bit          inf_disc [$];
    logic [31:0] buf_pc   [$];
    logic [31:0] buf_op   [$];

    always @(negedge clk) begin : model
        bit          e_req;
        bit          e_valid;
        bit          g;
        bit          dsc;
        logic [31:0] a;
        if (!reset) begin
            m_pc = RESET_PC;
            m_idle = 1'b1;
            m_halted = 1'b0;
            inf_addr.delete();
            inf_disc.delete();
            buf_pc.delete();
            buf_op.delete();
            check1("rst_req", mem_req_o, 1'b0);
            check1("rst_valid", valid_o, 1'b0);
            check32("rst_addr", mem_addr_o, RESET_PC);
            check32("rst_op", op_o, 32'h0);
            check32("rst_pc", pc_o, 32'h0);
        end else begin
            e_req   = !m_idle && !m_halted && (inf_addr.size() + buf_pc.size() < DEPTH);
            e_valid = buf_pc.size() > 0;
            check1("model_req", mem_req_o, e_req);
            check32("model_addr", mem_addr_o, m_pc);
            check1("model_valid", valid_o, e_valid);
            if (e_valid) begin
                check32("model_op", op_o, buf_op[0]);
                check32("model_pc", pc_o, buf_pc[0]);
            end
            g = e_req && mem_gnt_i;
            if (e_valid && ready_i) begin
                void'(buf_pc.pop_front());
                void'(buf_op.pop_front());
            end
            if (mem_rvalid_i && inf_addr.size() > 0) begin
                a   = inf_addr.pop_front();
                dsc = inf_disc.pop_front();
                if (!dsc && !flush_i) begin
                    buf_pc.push_back(a);
                    buf_op.push_back(mem_rdata_i);
                end
            end
            if (g) begin
                inf_addr.push_back(m_pc);
                inf_disc.push_back(flush_i);
            end
            if (flush_i) begin
                foreach (inf_disc[i]) inf_disc[i] = 1'b1;
                buf_pc.delete();
                buf_op.delete();
                m_pc = flush_pc_i;
            end else if (g) begin
                m_pc = m_pc + 32'd4;
            end
            if (m_idle) m_idle = 1'b0;
            else if (!m_halted && halt_i) m_halted = 1'b1;
            else if (m_halted && !halt_i) m_halted = 1'b0;
        end
    end

    initial begin
        logic [31:0] hold_op;
        logic [31:0] hold_pc;
        logic [31:0] last;
        int          n;
        int          n2;

        repeat (3) tick();
        check1("init_req", mem_req_o, 1'b0);
        check1("init_valid", valid_o, 1'b0);
        check32("init_addr", mem_addr_o, RESET_PC);

        // Straight-line fetch from reset, one-cycle memory.
        mem_gnt_i = 1'b1;
        ready_i   = 1'b1;
        reset     = 1'b1;
        repeat (12) tick();
        check1("t034_ngnt", gnt_log.size() >= 4, 1'b1);
        check1("t034_nacc", acc_pc.size() >= 4, 1'b1);
        if (gnt_log.size() >= 4 && acc_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check32("t034_gnt_addr", gnt_log[i], 32'(4 * i));
                check32("t034_pc", acc_pc[i], 32'(4 * i));
                check32("t034_op", acc_op[i], mem_word(32'(4 * i)));
            end
            check32("t034_rate", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
        end

        // Backpressure fills the buffer exactly to DEPTH.
        ready_i = 1'b0;
        tick();
        @(negedge clk);
        hold_op = op_o;
        hold_pc = pc_o;
        repeat (9) tick();
        @(negedge clk);
        check1("t035_valid", valid_o, 1'b1);
        check1("t035_req_low", mem_req_o, 1'b0);
        check32("t035_op_stable", op_o, hold_op);
        check32("t035_pc_stable", pc_o, hold_pc);
        acc_pc.delete();
        acc_op.delete();
        acc_cyc.delete();
        tick();
        mem_gnt_i = 1'b0;
        ready_i   = 1'b1;
        repeat (8) tick();
        check32("t035_drained", 32'(acc_pc.size()), 32'd4);
        if (acc_pc.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check32("t035_order", acc_pc[i], hold_pc + 32'(4 * i));
        end

        // Three outstanding at 0x10..0x18, then flush to 0x100.
        repeat (4) tick();
        mem_hold   = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h10;
        tick();
        flush_i   = 1'b0;
        mem_gnt_i = 1'b1;
        n = gnt_log.size();
        repeat (3) tick();
        mem_gnt_i = 1'b0;
        check32("t036_ngnt", 32'(gnt_log.size()), 32'(n + 3));
        if (gnt_log.size() >= n + 3) begin
            check32("t036_a0", gnt_log[n], 32'h10);
            check32("t036_a2", gnt_log[n+2], 32'h18);
        end
        flush_i    = 1'b1;
        flush_pc_i = 32'h100;
        tick();
        flush_i   = 1'b0;
        mem_hold  = 1'b0;
        mem_gnt_i = 1'b1;
        wait_valid("t036", 30);
        check32("t036_first_pc", pc_o, 32'h100);
        check32("t036_first_op", op_o, mem_word(32'h100));

        // Flush coinciding with a grant and a response.
        repeat (6) tick();
        flush_i    = 1'b1;
        flush_pc_i = 32'h200;
        @(negedge clk);
        check1("t037_gnt_in_flush", mem_req_o && mem_gnt_i, 1'b1);
        check1("t037_rsp_in_flush", mem_rvalid_i, 1'b1);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check1("t037_valid_dropped", valid_o, 1'b0);
        check1("t037_req_next", mem_req_o, 1'b1);
        check32("t037_addr_next", mem_addr_o, 32'h200);
        wait_valid("t037", 30);
        check32("t037_first_pc", pc_o, 32'h200);

        // Halt mid-stream, drain, resume sequentially.
        repeat (4) tick();
        halt_i = 1'b1;
        n = gnt_log.size();
        repeat (8) tick();
        @(negedge clk);
        check32("t038_grants", 32'(gnt_log.size()), 32'(n + 1));
        check1("t038_drained", valid_o, 1'b0);
        check1("t038_req_low", mem_req_o, 1'b0);
        last = gnt_log[gnt_log.size()-1];
        tick();
        halt_i = 1'b0;
        n2 = gnt_log.size();
        repeat (4) tick();
        check1("t038_resumed", gnt_log.size() > n2, 1'b1);
        if (gnt_log.size() > n2) check32("t038_resume_addr", gnt_log[n2], last + 32'd4);

        // PC wrap across 2^32.
        flush_i    = 1'b1;
        flush_pc_i = 32'hFFFF_FFF8;
        tick();
        flush_i = 1'b0;
        n = gnt_log.size();
        repeat (5) tick();
        check1("t039_nwrap", gnt_log.size() >= n + 3, 1'b1);
        if (gnt_log.size() >= n + 3) begin
            check32("t039_fc", gnt_log[n+1], 32'hFFFF_FFFC);
            check32("t039_wrap", gnt_log[n+2], 32'h0000_0000);
        end

        // Asynchronous reset with two outstanding and two buffered.
        mem_gnt_i = 1'b0;
        repeat (5) tick();
        ready_i   = 1'b0;
        mem_gnt_i = 1'b1;
        repeat (2) tick();
        mem_gnt_i = 1'b0;
        repeat (2) tick();
        mem_hold  = 1'b1;
        mem_gnt_i = 1'b1;
        repeat (2) tick();
        mem_gnt_i = 1'b0;
        tick();
        @(negedge clk);
        check1("t039_pre_valid", valid_o, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check1("t039_async_req", mem_req_o, 1'b0);
        check1("t039_async_valid", valid_o, 1'b0);
        check32("t039_async_addr", mem_addr_o, RESET_PC);
        check32("t039_async_op", op_o, 32'h0);
        check32("t039_async_pc", pc_o, 32'h0);
        repeat (2) tick();
        reset    = 1'b1;
        mem_hold = 1'b0;
        ready_i  = 1'b1;
        n = 0;
        while (mq_addr.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check1("t039_stale_gone", mq_addr.size() == 0, 1'b1);
        repeat (2) tick();
        spurious = 1'b1;
        repeat (2) tick();
        spurious = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check1("t039_stale_ignored", valid_o, 1'b0);
        tick();
        mem_gnt_i = 1'b1;
        n = gnt_log.size();
        repeat (3) tick();
        check1("t039_post_gnt", gnt_log.size() > n, 1'b1);
        if (gnt_log.size() > n) check32("t039_post_addr", gnt_log[n], RESET_PC);

        // Randomized traffic against the model.
        lat_extra = 3;
        for (int i = 0; i < 3000; i++) begin
            tick();
            mem_gnt_i  = ($urandom_range(0, 3) != 0);
            ready_i    = ($urandom_range(0, 3) != 0);
            flush_i    = ($urandom_range(0, 39) == 0);
            flush_pc_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 29) == 0) halt_i = !halt_i;
            mem_hold   = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 599) != 0);
        end
        tick();
        flush_i  = 1'b0;
        halt_i   = 1'b0;
        mem_hold = 1'b0;
        reset    = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
